// File: rtl/issue_queue_alu_pkg.sv
// Shared widths, payload field layout and issue-packet layout for the ALU issue queue.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
// Payload layout, MSB first: {uop, brmask, rd, pc, func, imm}.
// Issue packet layout, MSB first: {val, payload, rs2, rs1}.
package issue_queue_alu_pkg;

    localparam int IQ_WIDTH_REG = 7;
    localparam int IQ_WIDTH_BRM = 4;

    localparam int IQ_UOP_W  = 7;
    localparam int IQ_PC_W   = 32;
    localparam int IQ_FUNC_W = 10;
    localparam int IQ_IMM_W  = 32;

    localparam int IQ_IMM_LSB  = 0;
    localparam int IQ_FUNC_LSB = IQ_IMM_LSB + IQ_IMM_W;
    localparam int IQ_PC_LSB   = IQ_FUNC_LSB + IQ_FUNC_W;
    localparam int IQ_RD_LSB   = IQ_PC_LSB + IQ_PC_W;
    localparam int IQ_BRM_LSB  = IQ_RD_LSB + IQ_WIDTH_REG;
    localparam int IQ_UOP_LSB  = IQ_BRM_LSB + IQ_WIDTH_BRM;
    localparam int IQ_WIDTH_PL = IQ_UOP_LSB + IQ_UOP_W;

    localparam int IQ_ISSUE_W  = 1 + IQ_WIDTH_PL + 2 * IQ_WIDTH_REG;

    typedef struct packed {
        logic [IQ_UOP_W-1:0]     uop;
        logic [IQ_WIDTH_BRM-1:0] brmask;
        logic [IQ_WIDTH_REG-1:0] rd;
        logic [IQ_PC_W-1:0]      pc;
        logic [IQ_FUNC_W-1:0]    func;
        logic [IQ_IMM_W-1:0]     imm;
    } iq_payload_t;

    typedef struct packed {
        logic                    val;
        iq_payload_t             pl;
        logic [IQ_WIDTH_REG-1:0] rs2;
        logic [IQ_WIDTH_REG-1:0] rs1;
    } iq_issue_t;

    // brmask sits directly above the rd field, whose width follows the tag width.
    function automatic int iq_brm_lsb(input int width_reg);
        return IQ_IMM_W + IQ_FUNC_W + IQ_PC_W + width_reg;
    endfunction

endpackage

// File: rtl/issue_queue_alu_slot.sv
// One issue-queue entry: stored state, two wakeup comparators per source, branch-kill check.
// Latency: entry loads every clock; wakeup/kill views of the entry are combinational.
// Backpressure: none; the parent decides what is loaded each cycle.
// Ports: i_clk/i_rst, i_wk0/i_wk1 {valid,tag}, i_kill/i_kill_mask, i_ld_* next contents,
//        o_vld (alive after kill), o_rdy1/o_rdy2 (ready incl. this cycle's wakeup), o_elig, o_rs*/o_pl.
// IQ_BYPASS_WAKEUP_EN: when defined, a same-cycle wakeup makes the entry eligible immediately.
module iq_slot
    import issue_queue_alu_pkg::*;
#(
    parameter int WIDTH_REG = IQ_WIDTH_REG,
    parameter int WIDTH_BRM = IQ_WIDTH_BRM,
    parameter int WIDTH_PL  = IQ_WIDTH_PL,
    parameter int BRM_LSB   = IQ_BRM_LSB
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WIDTH_REG:0]   i_wk0,
    input  logic [WIDTH_REG:0]   i_wk1,
    input  logic                 i_kill,
    input  logic [WIDTH_BRM-1:0] i_kill_mask,
    input  logic                 i_ld_vld,
    input  logic                 i_ld_rdy1,
    input  logic                 i_ld_rdy2,
    input  logic [WIDTH_REG-1:0] i_ld_rs1,
    input  logic [WIDTH_REG-1:0] i_ld_rs2,
    input  logic [WIDTH_PL-1:0]  i_ld_pl,
    output logic                 o_vld,
    output logic                 o_rdy1,
    output logic                 o_rdy2,
    output logic                 o_elig,
    output logic [WIDTH_REG-1:0] o_rs1,
    output logic [WIDTH_REG-1:0] o_rs2,
    output logic [WIDTH_PL-1:0]  o_pl
);

    logic                 vld_q;
    logic                 rdy1_q;
    logic                 rdy2_q;
    logic [WIDTH_REG-1:0] rs1_q;
    logic [WIDTH_REG-1:0] rs2_q;
    logic [WIDTH_PL-1:0]  pl_q;

    logic hit1;
    logic hit2;
    logic killed;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q  <= 1'b0;
            rdy1_q <= 1'b0;
            rdy2_q <= 1'b0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            pl_q   <= '0;
        end else begin
            vld_q  <= i_ld_vld;
            rdy1_q <= i_ld_rdy1;
            rdy2_q <= i_ld_rdy2;
            rs1_q  <= i_ld_rs1;
            rs2_q  <= i_ld_rs2;
            pl_q   <= i_ld_pl;
        end
    end

    // Same tag on both buses simply ORs into a single wakeup.
    assign hit1 = (i_wk0[WIDTH_REG] && (i_wk0[WIDTH_REG-1:0] == rs1_q)) ||
                  (i_wk1[WIDTH_REG] && (i_wk1[WIDTH_REG-1:0] == rs1_q));
    assign hit2 = (i_wk0[WIDTH_REG] && (i_wk0[WIDTH_REG-1:0] == rs2_q)) ||
                  (i_wk1[WIDTH_REG] && (i_wk1[WIDTH_REG-1:0] == rs2_q));

    assign killed = i_kill && (|(pl_q[BRM_LSB +: WIDTH_BRM] & i_kill_mask));

    assign o_vld  = vld_q && !killed;
    assign o_rdy1 = rdy1_q || hit1;
    assign o_rdy2 = rdy2_q || hit2;

`ifdef IQ_BYPASS_WAKEUP_EN
    assign o_elig = o_vld && o_rdy1 && o_rdy2;
`else
    // Wakeup only lands in the ready bits; the entry competes next cycle.
    assign o_elig = o_vld && rdy1_q && rdy2_q;
`endif

    assign o_rs1 = rs1_q;
    assign o_rs2 = rs2_q;
    assign o_pl  = pl_q;

endmodule

// File: rtl/issue_queue_alu.sv
// Compacting ALU issue queue: oldest-first select of one ready entry per cycle, branch-kill flush.
// Latency: eligible entry appears on o_issue 1 cycle later; a fresh enqueue can issue the next cycle.
// Backpressure: o_full (registered) high when all DEPTH slots hold live entries; i_enq ignored then.
// Ports: i_clk, i_rst (async, active-high), i_enq/i_enq_pl/i_enq_rs1/i_enq_rs2/i_enq_rdy1/i_enq_rdy2,
//        o_full, i_wk0/i_wk1 {valid,tag}, i_kill/i_kill_mask, o_issue {val, payload, rs2, rs1}.
// IQ_BYPASS_WAKEUP_EN: when defined, an entry woken this cycle may be selected this cycle.
module issue_queue_alu
    import issue_queue_alu_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH_REG = IQ_WIDTH_REG,
    parameter int WIDTH_BRM = IQ_WIDTH_BRM,
    parameter int WIDTH_PL  = IQ_WIDTH_PL
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enq,
    input  logic [WIDTH_PL-1:0]           i_enq_pl,
    input  logic [WIDTH_REG-1:0]          i_enq_rs1,
    input  logic [WIDTH_REG-1:0]          i_enq_rs2,
    input  logic                          i_enq_rdy1,
    input  logic                          i_enq_rdy2,
    output logic                          o_full,
    input  logic [WIDTH_REG:0]            i_wk0,
    input  logic [WIDTH_REG:0]            i_wk1,
    input  logic                          i_kill,
    input  logic [WIDTH_BRM-1:0]          i_kill_mask,
    output logic [WIDTH_PL+2*WIDTH_REG:0] o_issue
);

    localparam int IW      = $clog2(DEPTH);
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int BRM_LSB = iq_brm_lsb(WIDTH_REG);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Current slot view (after this cycle's wakeup and kill).
    logic [DEPTH-1:0]     s_vld;
    logic [DEPTH-1:0]     s_rdy1;
    logic [DEPTH-1:0]     s_rdy2;
    logic [DEPTH-1:0]     s_elig;
    logic [WIDTH_REG-1:0] s_rs1 [DEPTH];
    logic [WIDTH_REG-1:0] s_rs2 [DEPTH];
    logic [WIDTH_PL-1:0]  s_pl  [DEPTH];

    // Next-cycle slot contents after compaction and enqueue.
    logic [DEPTH-1:0]     ld_vld;
    logic [DEPTH-1:0]     ld_rdy1;
    logic [DEPTH-1:0]     ld_rdy2;
    logic [WIDTH_REG-1:0] ld_rs1 [DEPTH];
    logic [WIDTH_REG-1:0] ld_rs2 [DEPTH];
    logic [WIDTH_PL-1:0]  ld_pl  [DEPTH];

    logic [DEPTH-1:0]     sel_oh;
    logic                 sel_any;
    logic [WIDTH_PL-1:0]  iss_pl_d;
    logic [WIDTH_REG-1:0] iss_rs1_d;
    logic [WIDTH_REG-1:0] iss_rs2_d;

    logic                 iss_vld_q;
    logic [WIDTH_PL-1:0]  iss_pl_q;
    logic [WIDTH_REG-1:0] iss_rs1_q;
    logic [WIDTH_REG-1:0] iss_rs2_q;
    logic                 full_q;
    logic                 full_d;

    logic                 enq_acc;
    logic                 enq_kill;
    logic                 enq_wr;
    logic                 enq_rdy1;
    logic                 enq_rdy2;
    logic [CW-1:0]        n_live;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        iq_slot #(
            .WIDTH_REG (WIDTH_REG),
            .WIDTH_BRM (WIDTH_BRM),
            .WIDTH_PL  (WIDTH_PL),
            .BRM_LSB   (BRM_LSB)
        ) u_slot (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_wk0       (i_wk0),
            .i_wk1       (i_wk1),
            .i_kill      (i_kill),
            .i_kill_mask (i_kill_mask),
            .i_ld_vld    (ld_vld[g]),
            .i_ld_rdy1   (ld_rdy1[g]),
            .i_ld_rdy2   (ld_rdy2[g]),
            .i_ld_rs1    (ld_rs1[g]),
            .i_ld_rs2    (ld_rs2[g]),
            .i_ld_pl     (ld_pl[g]),
            .o_vld       (s_vld[g]),
            .o_rdy1      (s_rdy1[g]),
            .o_rdy2      (s_rdy2[g]),
            .o_elig      (s_elig[g]),
            .o_rs1       (s_rs1[g]),
            .o_rs2       (s_rs2[g]),
            .o_pl        (s_pl[g])
        );
    end

    // Oldest eligible entry wins; slot 0 is the oldest.
    always_comb begin
        sel_oh    = '0;
        sel_any   = 1'b0;
        iss_pl_d  = '0;
        iss_rs1_d = '0;
        iss_rs2_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (s_elig[i] && !sel_any) begin
                sel_oh[i] = 1'b1;
                sel_any   = 1'b1;
                iss_pl_d  = s_pl[i];
                iss_rs1_d = s_rs1[i];
                iss_rs2_d = s_rs2[i];
            end
        end
    end

    assign enq_acc  = i_enq && !full_q;
    assign enq_kill = i_kill && (|(i_enq_pl[BRM_LSB +: WIDTH_BRM] & i_kill_mask));
    assign enq_wr   = enq_acc && !enq_kill;
    // A wakeup in the enqueue cycle is captured here, otherwise it would be missed.
    assign enq_rdy1 = i_enq_rdy1 ||
                      (i_wk0[WIDTH_REG] && (i_wk0[WIDTH_REG-1:0] == i_enq_rs1)) ||
                      (i_wk1[WIDTH_REG] && (i_wk1[WIDTH_REG-1:0] == i_enq_rs1));
    assign enq_rdy2 = i_enq_rdy2 ||
                      (i_wk0[WIDTH_REG] && (i_wk0[WIDTH_REG-1:0] == i_enq_rs2)) ||
                      (i_wk1[WIDTH_REG] && (i_wk1[WIDTH_REG-1:0] == i_enq_rs2));

    // Survivors (alive and not issued) pack down in age order; the enqueue lands just above them.
    // Accepting an enqueue implies fewer than DEPTH live entries, so n_live is a legal slot then.
    always_comb begin
        ld_vld  = '0;
        ld_rdy1 = '0;
        ld_rdy2 = '0;
        for (int j = 0; j < DEPTH; j++) begin
            ld_rs1[j] = '0;
            ld_rs2[j] = '0;
            ld_pl[j]  = '0;
        end
        n_live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (s_vld[i] && !sel_oh[i]) begin
                ld_vld[n_live[IW-1:0]]  = 1'b1;
                ld_rdy1[n_live[IW-1:0]] = s_rdy1[i];
                ld_rdy2[n_live[IW-1:0]] = s_rdy2[i];
                ld_rs1[n_live[IW-1:0]]  = s_rs1[i];
                ld_rs2[n_live[IW-1:0]]  = s_rs2[i];
                ld_pl[n_live[IW-1:0]]   = s_pl[i];
                n_live = n_live + CW'(1);
            end
        end
        if (enq_wr) begin
            ld_vld[n_live[IW-1:0]]  = 1'b1;
            ld_rdy1[n_live[IW-1:0]] = enq_rdy1;
            ld_rdy2[n_live[IW-1:0]] = enq_rdy2;
            ld_rs1[n_live[IW-1:0]]  = i_enq_rs1;
            ld_rs2[n_live[IW-1:0]]  = i_enq_rs2;
            ld_pl[n_live[IW-1:0]]   = i_enq_pl;
        end
    end

    assign full_d = ((n_live + CW'(enq_wr)) == DEPTH_C);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full_q    <= 1'b0;
            iss_vld_q <= 1'b0;
            iss_pl_q  <= '0;
            iss_rs1_q <= '0;
            iss_rs2_q <= '0;
        end else begin
            full_q    <= full_d;
            iss_vld_q <= sel_any;
            iss_pl_q  <= iss_pl_d;
            iss_rs1_q <= iss_rs1_d;
            iss_rs2_q <= iss_rs2_d;
        end
    end

    assign o_full  = full_q;
    assign o_issue = {iss_vld_q, iss_pl_q, iss_rs2_q, iss_rs1_q};

endmodule

// File: tb/tb_issue_queue_alu.sv
// Scoreboard bench for issue_queue_alu: expected issue packets are queued at stimulus time,
// a negedge monitor pops and compares whenever o_issue is valid.
module tb_issue_queue_alu;
    import issue_queue_alu_pkg::*;

    localparam int WR = IQ_WIDTH_REG;
    localparam int WB = IQ_WIDTH_BRM;
    localparam int WP = IQ_WIDTH_PL;
`ifdef IQ_BYPASS_WAKEUP_EN
    localparam int WAKE_GAP = 1;
`else
    localparam int WAKE_GAP = 2;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enq;
    logic [WP-1:0]         enq_pl;
    logic [WR-1:0]         rs1;
    logic [WR-1:0]         rs2;
    logic                  rdy1;
    logic                  rdy2;
    logic                  full;
    logic [WR:0]           wk0;
    logic [WR:0]           wk1;
    logic                  kill;
    logic [WB-1:0]         kill_mask;
    logic [IQ_ISSUE_W-1:0] issue;
    iq_issue_t             iss;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int stamp [64];
    iq_issue_t exp_q [$];
    iq_issue_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign iss = issue;

    issue_queue_alu dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enq       (enq),
        .i_enq_pl    (enq_pl),
        .i_enq_rs1   (rs1),
        .i_enq_rs2   (rs2),
        .i_enq_rdy1  (rdy1),
        .i_enq_rdy2  (rdy2),
        .o_full      (full),
        .i_wk0       (wk0),
        .i_wk1       (wk1),
        .i_kill      (kill),
        .i_kill_mask (kill_mask),
        .o_issue     (issue)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, want);
        end
    endtask

    function automatic iq_payload_t mk_pl(input int id, input logic [WB-1:0] brm);
        iq_payload_t p;
        p.uop    = 7'(id * 3 + 1);
        p.brmask = brm;
        p.rd     = 7'(id + 64);
        p.pc     = 32'h8000_0000 + 32'(id * 4);
        p.func   = 10'(id * 37);
        p.imm    = 32'(id) ^ 32'hA5A5_0000;
        return p;
    endfunction

    function automatic iq_issue_t mk_exp(input int id, input logic [WB-1:0] brm,
                                         input logic [WR-1:0] r1, input logic [WR-1:0] r2);
        iq_issue_t e;
        e.val = 1'b1;
        e.pl  = mk_pl(id, brm);
        e.rs1 = r1;
        e.rs2 = r2;
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_enq(input int id, input logic [WB-1:0] brm, input logic [WR-1:0] r1,
                             input logic [WR-1:0] r2, input logic d1, input logic d2);
        enq    = 1'b1;
        enq_pl = mk_pl(id, brm);
        rs1    = r1;
        rs2    = r2;
        rdy1   = d1;
        rdy2   = d2;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
        repeat (2) tick();
    endtask

    // Monitor: every valid issue must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && iss.val) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got imm=%0h, required no issue", iss.pl.imm);
            end else begin
                mon_e = exp_q.pop_front();
                chk("issue_pkt", issue, mon_e);
                stamp[mon_e.pl.imm[5:0]] = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int  c0;
        bit  dropped;
        rst = 1'b1; enq = 1'b0; enq_pl = '0; rs1 = '0; rs2 = '0; rdy1 = 1'b0; rdy2 = 1'b0;
        wk0 = '0; wk1 = '0; kill = 1'b0; kill_mask = '0;
        for (int i = 0; i < 64; i++) stamp[i] = 0;
        repeat (2) tick();
        chk("rst_full", full, 0);
        chk("rst_issue_val", iss.val, 0);
        rst = 1'b0;
        tick();

        // Fill all 8 slots waiting on tag 0x30, then hold an extra enqueue while full.
        for (int k = 0; k < 8; k++) begin
            drive_enq(k, 4'b0000, 7'h30, 7'h31, 1'b0, 1'b1);
            exp_q.push_back(mk_exp(k, 4'b0000, 7'h30, 7'h31));
            if (k == 7) chk("full_before_last_enq", full, 0);
            tick();
        end
        chk("full_after_8", full, 1);
        drive_enq(8, 4'b0000, 7'h01, 7'h02, 1'b1, 1'b1);
        exp_q.push_back(mk_exp(8, 4'b0000, 7'h01, 7'h02));
        tick();
        tick();
        chk("full_while_held", full, 1);
        wk1 = {1'b1, 7'h30};
        tick();
        wk1 = '0;
        dropped = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!full) begin
                dropped = 1'b1;
                break;
            end
            tick();
        end
        chk("full_dropped", dropped, 1);
        chk("full_low_with_first_issue", iss.val, 1);
        tick();
        enq = 1'b0;
        wait_drain("fill");
        chk("burst_consecutive", stamp[7] - stamp[0], 7);

        // Dependent pair: A waits on 0x05, B is ready; B's result wakes A.
        drive_enq(10, 4'b0000, 7'h05, 7'h06, 1'b0, 1'b1);
        tick();
        drive_enq(11, 4'b0000, 7'h01, 7'h02, 1'b1, 1'b1);
        exp_q.push_back(mk_exp(11, 4'b0000, 7'h01, 7'h02));
        exp_q.push_back(mk_exp(10, 4'b0000, 7'h05, 7'h06));
        tick();
        enq = 1'b0;
        tick();
        chk("b_issued_first", iss.pl.imm, mk_pl(11, 4'b0000).imm);
        wk0 = {1'b1, 7'h05};
        tick();
        wk0 = '0;
        wait_drain("dep_pair");
        chk("dep_wake_gap", stamp[10] - stamp[11], WAKE_GAP);

        // Wakeup coincident with enqueue is captured.
        c0 = cyc;
        drive_enq(12, 4'b0000, 7'h10, 7'h11, 1'b1, 1'b0);
        wk1 = {1'b1, 7'h11};
        exp_q.push_back(mk_exp(12, 4'b0000, 7'h10, 7'h11));
        tick();
        enq = 1'b0;
        wk1 = '0;
        wait_drain("enq_wake");
        chk("enq_wake_latency", stamp[12], c0 + 2);

        // Branch kill: middle entry and a same-cycle enqueue share mask 0010.
        drive_enq(20, 4'b0001, 7'h20, 7'h21, 1'b0, 1'b1);
        exp_q.push_back(mk_exp(20, 4'b0001, 7'h20, 7'h21));
        tick();
        drive_enq(21, 4'b0010, 7'h20, 7'h21, 1'b0, 1'b1);
        tick();
        drive_enq(22, 4'b0100, 7'h20, 7'h21, 1'b0, 1'b1);
        exp_q.push_back(mk_exp(22, 4'b0100, 7'h20, 7'h21));
        tick();
        drive_enq(23, 4'b0010, 7'h01, 7'h02, 1'b1, 1'b1);
        kill = 1'b1;
        kill_mask = 4'b0010;
        wk0 = {1'b1, 7'h20};
        tick();
        enq = 1'b0; kill = 1'b0; kill_mask = '0; wk0 = '0;
        wait_drain("kill_mid");

        // Ready entry killed in the cycle it would be selected never issues.
        drive_enq(24, 4'b1000, 7'h01, 7'h02, 1'b1, 1'b1);
        tick();
        enq = 1'b0;
        kill = 1'b1;
        kill_mask = 4'b1000;
        tick();
        kill = 1'b0;
        kill_mask = '0;
        repeat (5) tick();
        chk("kill_cand_no_issue", iss.val, 0);

        // Reset with 5 entries resident; the ready one is on o_issue when reset hits.
        for (int k = 0; k < 4; k++) begin
            drive_enq(30 + k, 4'b0001, 7'h7E, 7'h7D, 1'b0, 1'b1);
            tick();
        end
        drive_enq(34, 4'b0001, 7'h01, 7'h02, 1'b1, 1'b1);
        exp_q.push_back(mk_exp(34, 4'b0001, 7'h01, 7'h02));
        tick();
        enq = 1'b0;
        tick();
        chk("pre_rst_issue_val", iss.val, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_issue_val", iss.val, 0);
        chk("rst_async_full", full, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_issue_val", iss.val, 0);
        wk0 = {1'b1, 7'h7E};
        wk1 = {1'b1, 7'h7E};
        tick();
        wk0 = '0;
        wk1 = '0;
        repeat (6) tick();
        chk("post_rst_full", full, 0);
        drive_enq(40, 4'b0000, 7'h03, 7'h04, 1'b1, 1'b1);
        exp_q.push_back(mk_exp(40, 4'b0000, 7'h03, 7'h04));
        tick();
        enq = 1'b0;
        wait_drain("post_rst");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
